// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_exec_unit: RV32I execute-stage ALU, combinational decode, reg result |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct,
  input  logic             add_rshift_type,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       ALUop,
  output logic [WIDTH-1:0] Out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_CPYB = 4'd10;
  localparam logic [3:0] OP_XXX  = 4'd15;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IARITH = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [3:0]       alu_op;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  // Shared funct3 table for R-type and I-arith; only I-arith forces 000 to ADD.
  always_comb begin
    alu_op = OP_XXX;
    case (opcode)
      OPC_RTYPE, OPC_IARITH: begin
        case (funct)
          3'b000:  alu_op = (add_rshift_type && (opcode == OPC_RTYPE)) ? OP_SUB : OP_ADD;
          3'b001:  alu_op = OP_SLL;
          3'b010:  alu_op = OP_SLT;
          3'b011:  alu_op = OP_SLTU;
          3'b100:  alu_op = OP_XOR;
          3'b101:  alu_op = add_rshift_type ? OP_SRA : OP_SRL;
          3'b110:  alu_op = OP_OR;
          default: alu_op = OP_AND;
        endcase
      end
      OPC_LUI: alu_op = OP_CPYB;
      OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR:
        alu_op = OP_ADD;
      default: alu_op = OP_XXX;
    endcase
  end

  assign shamt = B[4:0];

  always_comb begin
    out_d = '0;
    case (alu_op)
      OP_ADD:  out_d = A + B;
      OP_SUB:  out_d = A - B;
      OP_AND:  out_d = A & B;
      OP_OR:   out_d = A | B;
      OP_XOR:  out_d = A ^ B;
      OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: out_d = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  out_d = A << shamt;
      OP_SRA:  out_d = $unsigned($signed(A) >>> shamt);
      OP_SRL:  out_d = A >> shamt;
      OP_CPYB: out_d = B;
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

  assign ALUop = alu_op;
  assign Out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_exec_unit: directed vectors for alu_exec_unit                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        t30;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_op;
  logic [31:0] out;

  int passed;
  int total;

  alu_exec_unit #(.WIDTH(32)) dut (
    .Clock(clk), .Reset_n(rst_n), .opcode(opcode), .funct(funct),
    .add_rshift_type(t30), .A(a), .B(b), .ALUop(alu_op), .Out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Drive at negedge, check decode immediately, check result after next posedge.
  task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f,
                       input logic t, input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] exp_op, input logic [31:0] exp_out);
    @(negedge clk);
    opcode = op; funct = f; t30 = t; a = av; b = bv;
    #1 check({tag, ".aluop"}, {28'd0, alu_op}, {28'd0, exp_op});
    @(posedge clk);
    #1 check({tag, ".out"}, out, exp_out);
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; opcode = 7'b0110011; funct = 3'b000; t30 = 1'b0;
    a = 32'd3; b = 32'd4;
    repeat (2) @(posedge clk);
    #1 check("reset.out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("sub",   7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 4'd1, 32'hFFFFFFFE);
    apply("add",   7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 4'd0, 32'd12);
    apply("addi",  7'b0010011, 3'b000, 1'b1, 32'hFFFFFFFF, 32'd1, 4'd0, 32'h0);
    apply("sra",   7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'h24, 4'd8, 32'hF8000000);
    apply("srl",   7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'h24, 4'd9, 32'h08000000);
    apply("srai",  7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h1, 4'd8, 32'hC0000000);
    apply("slt",   7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd5, 32'h1);
    apply("sltu",  7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd6, 32'h0);
    apply("sltu2", 7'b0010011, 3'b011, 1'b0, 32'd1, 32'hFFFFFFFF, 4'd6, 32'h1);
    apply("sll",   7'b0110011, 3'b001, 1'b0, 32'd1, 32'h3F, 4'd7, 32'h80000000);
    apply("xor",   7'b0110011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0);
    apply("or",    7'b0110011, 3'b110, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 32'hFFF0FFF0);
    apply("and",   7'b0010011, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000);
    apply("lui",   7'b0110111, 3'b010, 1'b1, 32'h1234, 32'hABCDE000, 4'd10, 32'hABCDE000);
    apply("branch",7'b1100011, 3'b101, 1'b1, 32'h100, 32'h8, 4'd0, 32'h108);
    apply("auipc", 7'b0010111, 3'b001, 1'b0, 32'h1000, 32'h2000, 4'd0, 32'h3000);
    apply("load",  7'b0000011, 3'b010, 1'b1, 32'h10, 32'hFFFFFFFC, 4'd0, 32'hC);
    apply("store", 7'b0100011, 3'b000, 1'b1, 32'h20, 32'h4, 4'd0, 32'h24);
    apply("jal",   7'b1101111, 3'b111, 1'b1, 32'h40, 32'h40, 4'd0, 32'h80);
    apply("jalr",  7'b1100111, 3'b000, 1'b1, 32'h7, 32'h9, 4'd0, 32'h10);
    apply("unk",   7'b1111111, 3'b000, 1'b0, 32'h5, 32'h6, 4'd15, 32'h0);

    // Load a nonzero result, then assert reset mid-stream with a live op on the inputs.
    apply("pre_rst", 7'b0110111, 3'b000, 1'b0, 32'h0, 32'hDEADBEEF, 4'd10, 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b0; opcode = 7'b0110111; b = 32'h12345678;
    #1 check("rst.aluop", {28'd0, alu_op}, 32'd10);
    @(posedge clk);
    #1 check("rst.out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_rel.hold", out, 32'h0);
    @(posedge clk);
    #1 check("rst_rel.out", out, 32'h12345678);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
